// File: rtl/seg7_scan_if.sv
// Display-side bundle for seg7_scan: the BCD time word and mode bits
// from the stopwatch, and the scanned segment/anode outputs.
interface seg7_scan_if;
    logic [16:1] Q;
    logic        RUNNING;
    logic        BLANK_LZ;
    logic [7:1]  SEG;
    logic        DP;
    logic [4:1]  AN;

    modport master (
        output Q,
        output RUNNING,
        output BLANK_LZ,
        input  SEG,
        input  DP,
        input  AN
    );

    modport slave (
        input  Q,
        input  RUNNING,
        input  BLANK_LZ,
        output SEG,
        output DP,
        output AN
    );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit time-multiplexed 7-segment driver with anode dead-time,
// per-frame snapshot of the time word and a blinking colon on digit 3.
module seg7_scan #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int DEAD_CYCLES  = 500,
    parameter int BLINK_FRAMES = 50,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        RESET_N,
    seg7_scan_if.slave  disp
);

    localparam int PW = $clog2(SLOT_CYCLES);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(SLOT_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic       DP_OFF  = ACTIVE_LOW;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [16:1]   snap_q, snap_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          blink_q, blink_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    digit;
    logic [6:0]    pattern;
    logic          in_dead;
    logic          lz_blank;
    logic          an_on;
    logic [3:0]    an_hi;
    logic [6:0]    seg_hi;
    logic          dp_hi;

    // Slot/frame sequencing; snap and the blink divider only move at frame end
    always_comb begin
        slot_end  = (pcnt_q == PCNT_LAST);
        frame_end = slot_end && (idx_q == 2'd3);

        pcnt_d  = slot_end ? '0 : pcnt_q + 1'b1;
        idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
        snap_d  = frame_end ? disp.Q : snap_q;
        fcnt_d  = fcnt_q;
        blink_d = blink_q;

        if (frame_end) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx_q)
            2'd0: digit = snap_q[4:1];
            2'd1: digit = snap_q[8:5];
            2'd2: digit = snap_q[12:9];
            2'd3: digit = snap_q[16:13];
            default: digit = 4'd0;
        endcase
    end

    // Pattern bits are {g,f,e,d,c,b,a}; non-BCD codes show a dash
    always_comb begin
        pattern = 7'h40;
        case (digit)
            4'd0: pattern = 7'h3F;
            4'd1: pattern = 7'h06;
            4'd2: pattern = 7'h5B;
            4'd3: pattern = 7'h4F;
            4'd4: pattern = 7'h66;
            4'd5: pattern = 7'h6D;
            4'd6: pattern = 7'h7D;
            4'd7: pattern = 7'h07;
            4'd8: pattern = 7'h7F;
            4'd9: pattern = 7'h6F;
            default: pattern = 7'h40;
        endcase
    end

    always_comb begin
        in_dead  = (int'(pcnt_q) < DEAD_CYCLES);
        lz_blank = (idx_q == 2'd3) && disp.BLANK_LZ && (snap_q[16:13] == 4'd0);
        an_on    = !in_dead && !lz_blank;

        an_hi  = an_on ? (4'b0001 << idx_q) : 4'b0000;
        seg_hi = an_on ? pattern : 7'h00;
        dp_hi  = an_on && (idx_q == 2'd2) && (!disp.RUNNING || blink_q);

        // Polarity is folded in before the output registers
        an_d  = an_hi  ^ {4{ACTIVE_LOW}};
        seg_d = seg_hi ^ {7{ACTIVE_LOW}};
        dp_d  = dp_hi  ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            pcnt_q  <= '0;
            idx_q   <= 2'd0;
            snap_q  <= '0;
            fcnt_q  <= '0;
            blink_q <= 1'b1;
            seg_q   <= SEG_OFF;
            dp_q    <= DP_OFF;
            an_q    <= AN_OFF;
        end else begin
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            fcnt_q  <= fcnt_d;
            blink_q <= blink_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign disp.SEG = seg_q;
    assign disp.DP  = dp_q;
    assign disp.AN  = an_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized self-checking bench for seg7_scan against a cycle-indexed
// reference model (slot/frame arithmetic from elapsed cycles since reset).
module tb_seg7_scan;

   localparam int SLOT   = 8;
   localparam int DEAD   = 2;
   localparam int BLINKF = 2;
   localparam int FRAME  = 4 * SLOT;

   logic clk = 1'b0;
   logic RESET_N;
   seg7_scan_if bus();

   seg7_scan #(
      .SLOT_CYCLES (SLOT),
      .DEAD_CYCLES (DEAD),
      .BLINK_FRAMES(BLINKF),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk    (clk),
      .RESET_N(RESET_N),
      .disp   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int t;
   logic [15:0] snapM;
   logic [6:0] segTab [16];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s at t=%0d (time %0t): got %h, expected %h", tag, t, $time, observed, expected);
      end
   endtask

   // Model: the output after an edge reflects the state t cycles after reset release
   task automatic applyStimulus();
      int p, slot, idx, frame;
      logic [3:0] dig;
      logic anOn, blinkM;
      logic [3:0] expAn;
      logic [6:0] expSeg;
      logic expDp;
      logic [15:0] qNow;
      p      = t % SLOT;
      slot   = t / SLOT;
      idx    = slot % 4;
      frame  = t / FRAME;
      dig    = snapM[4*idx +: 4];
      anOn   = (p >= DEAD) && !(idx == 3 && bus.BLANK_LZ && snapM[15:12] == 4'd0);
      blinkM = ((frame / BLINKF) % 2) == 0;
      expAn  = anOn ? ~(4'b0001 << idx) : 4'hF;
      expSeg = anOn ? ~segTab[dig] : 7'h7F;
      expDp  = (anOn && idx == 2 && (!bus.RUNNING || blinkM)) ? 1'b0 : 1'b1;
      qNow   = bus.Q;
      @(posedge clk);
      #1;
      checkOutput("AN", bus.AN, expAn);
      checkOutput("SEG", bus.SEG, expSeg);
      checkOutput("DP", bus.DP, expDp);
      checkOutput("onehot", ((4 - $countones(bus.AN)) <= 1), 1);
      if (t % FRAME == FRAME - 1) snapM = qNow;
      t++;
   endtask

   task automatic runTo(input int target);
      while (t < target) applyStimulus();
   endtask

   function automatic logic [15:0] randBcd();
      logic [15:0] v;
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 5) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
         else v[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 2) == 0) v[15:12] = 4'd0;
      return v;
   endfunction

   initial begin
      segTab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      t = 0;
      snapM = '0;
      RESET_N = 1'b0;
      bus.Q = 16'h1234;
      bus.RUNNING = 1'b0;
      bus.BLANK_LZ = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstAN", bus.AN, 4'hF);
      checkOutput("rstSEG", bus.SEG, 7'h7F);
      checkOutput("rstDP", bus.DP, 1);

      @(negedge clk);
      RESET_N = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("firstDead", bus.AN, 4'hF);
      applyStimulus();
      checkOutput("firstAN", bus.AN, 4'hE);
      checkOutput("firstSEG", bus.SEG, 7'h40);

      runTo(35);
      checkOutput("frame2AN", bus.AN, 4'hE);
      checkOutput("frame2SEG", bus.SEG, 7'h19);
      runTo(10 * FRAME);

      // Tearing: Q changes mid-frame must wait for the next frame
      bus.Q = 16'h0959;
      runTo(11 * FRAME);
      runTo(11 * FRAME + 10);
      bus.Q = 16'h1000;
      runTo(11 * FRAME + 2 * SLOT + 3);
      checkOutput("tearSEG", bus.SEG, 7'h10);
      runTo(12 * FRAME + 3);
      checkOutput("newSEG0", bus.SEG, 7'h40);
      runTo(12 * FRAME + 3 * SLOT + 4);
      checkOutput("newAN3", bus.AN, 4'h7);
      checkOutput("newSEG3", bus.SEG, 7'h79);

      // Invalid BCD and leading-zero blanking
      bus.Q = 16'h0A05;
      bus.BLANK_LZ = 1'b1;
      runTo(13 * FRAME + 2 * SLOT + 3);
      checkOutput("dashAN", bus.AN, 4'hB);
      checkOutput("dashSEG", bus.SEG, 7'h3F);
      runTo(13 * FRAME + 3 * SLOT + 3);
      checkOutput("lzAN", bus.AN, 4'hF);
      checkOutput("lzSEG", bus.SEG, 7'h7F);
      bus.BLANK_LZ = 1'b0;
      runTo(13 * FRAME + 3 * SLOT + 4);
      checkOutput("noLzAN", bus.AN, 4'h7);
      checkOutput("noLzSEG", bus.SEG, 7'h40);

      // Colon: steady, then blinking two frames lit, two dark
      runTo(16 * FRAME);
      bus.RUNNING = 1'b1;
      runTo(16 * FRAME + 2 * SLOT + 4);
      checkOutput("blinkLit", bus.DP, 0);
      runTo(18 * FRAME + 2 * SLOT + 4);
      checkOutput("blinkDark", bus.DP, 1);
      runTo(24 * FRAME);

      // Randomized inputs changing on arbitrary cycles
      while (t < 44 * FRAME) begin
         if ($urandom_range(0, 7) == 0) bus.Q = randBcd();
         if ($urandom_range(0, 39) == 0) bus.RUNNING = ~bus.RUNNING;
         if ($urandom_range(0, 39) == 0) bus.BLANK_LZ = ~bus.BLANK_LZ;
         applyStimulus();
      end

      // Async reset in slot 2 between clock edges
      bus.Q = 16'h1234;
      bus.BLANK_LZ = 1'b0;
      runTo(45 * FRAME + 2 * SLOT + 5);
      checkOutput("preRstAN", bus.AN, 4'hB);
      #2;
      RESET_N = 1'b0;
      #1;
      checkOutput("asyncAN", bus.AN, 4'hF);
      checkOutput("asyncSEG", bus.SEG, 7'h7F);
      checkOutput("asyncDP", bus.DP, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      RESET_N = 1'b1;
      t = 0;
      snapM = '0;
      checkOutput("relAN0", bus.AN, 4'hF);
      applyStimulus();
      checkOutput("relAN1", bus.AN, 4'hF);
      applyStimulus();
      checkOutput("relAN2", bus.AN, 4'hF);
      applyStimulus();
      checkOutput("relAN3", bus.AN, 4'hE);
      runTo(2 * FRAME);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
